uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver with configurable frame format, error detection and a first-word-fall-through receive FIFO. It replaces the fixed 8N1 receive path behind the CPU's memory-mapped UART: it takes `FPGA_SERIAL_RX` and gives the core a ready/valid byte stream plus sticky error flags. It is the synthesizable counterpart of the host-side serial model used by the BIOS bench. It adds what the 8N1 path lacks: 5–9 data bits, optional parity, 1 or 2 stop bits, buffering, and overrun/framing/parity reporting.

## Interface
Parameters:
- `CLOCK_FREQ`, default 50_000_000: clk frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate. `SAMPLE_TIME = CLOCK_FREQ / BAUD_RATE`, integer division, truncating.
- `DATA_BITS`, default 8: payload width. Legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 8: receive FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset. Asynchronous, active-high.
- `serial_in`  in  1: asynchronous line. Idle high.
- `data_out`  out  DATA_BITS: FIFO head. First-word-fall-through.
- `data_out_valid`  out  1: FIFO non-empty.
- `data_out_ready`  in  1: consumer accepts the head.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: entries held.
- `frame_err`  out  1: sticky. A stop bit was sampled low.
- `parity_err`  out  1: sticky. Parity mismatch.
- `overrun`  out  1: sticky. A good frame arrived while the FIFO was full.
- `err_clear`  in  1: one-cycle pulse. Clears all three sticky flags.

## Operation
- Input conditioning: `serial_in` passes through a 2-flop synchronizer reset to 1. All decisions use the synchronized value `rx_s`.
- Arming: after reset, the receiver stays in ARM until `rx_s` is high for 1 cycle, then goes to IDLE. A frame already in flight at reset release is therefore never captured.
- Receive FSM: ARM → IDLE → START → DATA → PARITY (only if `PARITY != 0`) → STOP → COMMIT → IDLE.
  - IDLE: `rx_s == 0` → START. The baud counter loads `SAMPLE_TIME/2`.
  - START: at counter expiry, sample `rx_s`.
    - Sample = 1: false start, go to IDLE.
    - Sample = 0: go to DATA. The counter reloads `SAMPLE_TIME` on every bit from here on.
  - DATA: sample `DATA_BITS` bits, LSB first, at each mid-bit point.
  - PARITY: sample one bit and compare.
    - Odd: XOR of data and parity bit must be 1.
    - Even: XOR of data and parity bit must be 0.
  - STOP: sample `STOP_BITS` bits. Any low sample marks a framing error.
  - COMMIT (1 cycle):
    - Framing error: drop the frame, set `frame_err`, go to ARM. ARM waits for an idle-high line, which absorbs a line break.
    - Else parity error: drop the frame, set `parity_err`, go to IDLE.
    - Else FIFO full and no pop in this cycle: drop the frame, set `overrun`, go to IDLE.
    - Else: push the frame, go to IDLE.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the index.
  - Empty when pointers are equal. Full when indices are equal and the MSBs differ.
  - A pop happens when `data_out_valid && data_out_ready`.
  - Push and pop in the same cycle are both honoured, including when full. `fifo_count` is then unchanged and no overrun is flagged.
  - Pop when empty is ignored.
- Sticky flags: `err_clear` clears them. If a set and `err_clear` land in the same cycle, the set wins and the flag stays 1.

## Timing
- Reset values:
  - `data_out_valid = 0`, `fifo_count = 0`.
  - `frame_err = parity_err = overrun = 0`.
  - `data_out = 0`.
  - FSM in ARM.
- Assertion of `rst` at any time, including mid-frame or with the FIFO non-empty, immediately discards all state.
- Line-to-decision latency: 2 cycles of synchronizer plus `SAMPLE_TIME/2` to the start-bit sample.
- Each subsequent sample falls exactly `SAMPLE_TIME` cycles after the previous one. There is no resynchronization within a frame.
- Flag and FIFO update timing:
  - The last stop-bit sample is cycle N. COMMIT is cycle N+1.
  - `data_out_valid`, `fifo_count` and all error flags update at the clock edge ending N+1, so they are visible from cycle N+2.
- Pop timing: `data_out` shows the next entry in the cycle after a pop. There is no read bubble.
- Back-to-back frames: a start edge seen in the cycle after COMMIT is accepted. The minimum accepted inter-frame gap is the stop-bit time only.

## Test plan
Defaults unless stated: 50 MHz, 115200 baud, `SAMPLE_TIME = 434`.
- 8N1 and sustained traffic:
  - Send 0x61, 0x62, 0x63, 0x64 back-to-back with `data_out_ready = 0`. Expect `fifo_count = 4`, then pops yield 61, 62, 63, 64 in order with no error flags.
  - Send 12 frames with `data_out_ready = 0`. Expect `fifo_count = 8`, `overrun = 1`, and frames 9..12 lost.
  - Pulse `err_clear`. Expect `overrun = 0`.
- Parity (`PARITY = 2`, `DATA_BITS = 7`):
  - Send 0x41 with a correct even-parity bit. Expect 0x41 received.
  - Send 0x41 with the parity bit flipped. Expect no push and `parity_err = 1`.
- Framing error and break: send 0x55 with the stop bit held low, then hold the line low for 20 bit times, then release. Expect `frame_err = 1`, `fifo_count = 0`, and the next normal frame 0x5A received correctly.
- False start: drive a low glitch on the line lasting 100 cycles. Expect no frame, the FSM back in IDLE, and all flags at 0.
- Reset mid-frame: assert `rst` during data bit 3 while the FIFO holds 2 entries. Expect `fifo_count = 0` and `data_out_valid = 0`, the remainder of the frame ignored, and the next frame received.
- Corner format (`DATA_BITS = 9`, `STOP_BITS = 2`, `PARITY = 1`): send 0x1A5. Expect 0x1A5. Then set one stop bit low. Expect `frame_err = 1`.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with a two-flop input synchronizer,
// a frame FSM, a first-word-fall-through receive FIFO and sticky error flags.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_ARM    | waiting for an idle-high line after reset or framing error
// S_IDLE   | line idle, watching for a falling start edge
// S_START  | timing to the middle of the start bit, rejects glitches
// S_DATA   | sampling payload bits, LSB first
// S_PARITY | sampling and checking the parity bit
// S_STOP   | sampling stop bit(s), any low sample is a framing error
// S_COMMIT | one cycle: push the frame or record why it was dropped
`timescale 1ns/1ps
module uart_rx_param #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          err_clear
);

    localparam int SAMPLE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(SAMPLE_TIME);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);

    // Counter expires at zero, so loads are one less than the wanted cycle count.
    localparam logic [CW-1:0] FULL_LOAD = CW'(SAMPLE_TIME - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(SAMPLE_TIME / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_ARM, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_COMMIT
    } state_t;

    logic            sync_a;
    logic            rx_s;
    logic [1:0]      sync_fill;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [BW-1:0]   bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic            par_bad, par_bad_n;
    logic            stop_bad, stop_bad_n;
    logic            stop_idx, stop_idx_n;

    logic            push, set_fe, set_pe, set_ov;
    logic            tick;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]     wptr, rptr;
    logic            empty, full, pop;

    // Two-flop synchronizer; sync_fill marks when rx_s holds a real line sample
    // rather than the reset value, so ARM cannot be satisfied by reset alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a    <= 1'b1;
            rx_s      <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            sync_a    <= serial_in;
            rx_s      <= sync_a;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // FSM and frame datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_ARM;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            stop_idx <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            par_bad  <= par_bad_n;
            stop_bad <= stop_bad_n;
            stop_idx <= stop_idx_n;
        end
    end

    assign tick = (cnt == '0);

    // Next-state, sampling and commit decisions.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        par_bad_n  = par_bad;
        stop_bad_n = stop_bad;
        stop_idx_n = stop_idx;
        push       = 1'b0;
        set_fe     = 1'b0;
        set_pe     = 1'b0;
        set_ov     = 1'b0;
        case (state)
            S_ARM: begin
                if (sync_fill[1] && rx_s) state_n = S_IDLE;
            end
            S_IDLE: begin
                if (!rx_s) begin
                    state_n = S_START;
                    cnt_n   = HALF_LOAD;
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else if (rx_s) begin
                    state_n = S_IDLE;
                end else begin
                    state_n   = S_DATA;
                    cnt_n     = FULL_LOAD;
                    bit_idx_n = '0;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    cnt_n   = FULL_LOAD;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_idx == LAST_BIT) begin
                        state_n    = (PARITY != 0) ? S_PARITY : S_STOP;
                        par_bad_n  = 1'b0;
                        stop_bad_n = 1'b0;
                        stop_idx_n = 1'b0;
                    end else begin
                        bit_idx_n = bit_idx + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    cnt_n     = FULL_LOAD;
                    par_bad_n = (PARITY == 1) ? ~(^shreg ^ rx_s) : (^shreg ^ rx_s);
                    state_n   = S_STOP;
                end
            end
            S_STOP: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    cnt_n = FULL_LOAD;
                    if (!rx_s) stop_bad_n = 1'b1;
                    if (stop_idx == LAST_STOP) state_n = S_COMMIT;
                    else stop_idx_n = stop_idx + 1'b1;
                end
            end
            S_COMMIT: begin
                state_n = S_IDLE;
                if (stop_bad) begin
                    set_fe  = 1'b1;
                    state_n = S_ARM;
                end else if (par_bad) begin
                    set_pe = 1'b1;
                end else if (full && !pop) begin
                    set_ov = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            default: state_n = S_ARM;
        endcase
    end

    assign empty          = (wptr == rptr);
    assign full           = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign data_out_valid = !empty;
    assign pop            = data_out_valid && data_out_ready;
    assign fifo_count     = wptr - rptr;
    assign data_out       = empty ? '0 : mem[rptr[AW-1:0]];

    // FIFO storage; contents need no reset because reads are masked when empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= shreg;
    end

    // FIFO pointers; a push into a full FIFO is only issued alongside a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Sticky error flags; a set in the same cycle as err_clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (set_fe)         frame_err <= 1'b1;
            else if (err_clear) frame_err <= 1'b0;
            if (set_pe)         parity_err <= 1'b1;
            else if (err_clear) parity_err <= 1'b0;
            if (set_ov)         overrun <= 1'b1;
            else if (err_clear) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: three receiver instances (8N1 depth 8, 7E1 depth 4,
// 9O2 depth 2) driven bit-by-bit and compared with a queue-based frame model.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int CF = 1_000_000;
    localparam int BR = 60_000;
    localparam int BT = CF / BR;    // 16 cycles per bit (truncated from 16.67)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ln  = 3'b111;
    logic [2:0] rdy = 3'b000;
    logic [2:0] clr = 3'b000;

    logic [7:0] do0;
    logic [6:0] do1;
    logic [8:0] do2;
    logic [2:0] vld, fe, pe, ov;
    logic [3:0] c0;
    logic [2:0] c1;
    logic [1:0] c2;

    int n_checks = 0;
    int n_fail   = 0;

    int  q0[$], q1[$], q2[$];
    bit  efe[3], epe[3], eov[3];

    always #5 clk = ~clk;

    uart_rx_param #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(8)) u0 (
        .clk(clk), .rst(rst), .serial_in(ln[0]), .data_out(do0),
        .data_out_valid(vld[0]), .data_out_ready(rdy[0]), .fifo_count(c0),
        .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]), .err_clear(clr[0]));

    uart_rx_param #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(2),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .serial_in(ln[1]), .data_out(do1),
        .data_out_valid(vld[1]), .data_out_ready(rdy[1]), .fifo_count(c1),
        .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]), .err_clear(clr[1]));

    uart_rx_param #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(9), .PARITY(1),
                    .STOP_BITS(2), .FIFO_DEPTH(2)) u2 (
        .clk(clk), .rst(rst), .serial_in(ln[2]), .data_out(do2),
        .data_out_valid(vld[2]), .data_out_ready(rdy[2]), .fifo_count(c2),
        .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ov[2]), .err_clear(clr[2]));

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int dbits(input int i);
        return (i == 0) ? 8 : (i == 1) ? 7 : 9;
    endfunction
    function automatic int pmode(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 1;
    endfunction
    function automatic int nstop(input int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic int depth(input int i);
        return (i == 0) ? 8 : (i == 1) ? 4 : 2;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
    endfunction
    function automatic int get_cnt(input int i);
        return (i == 0) ? int'(c0) : (i == 1) ? int'(c1) : int'(c2);
    endfunction
    function automatic int get_data(input int i);
        return (i == 0) ? int'(do0) : (i == 1) ? int'(do1) : int'(do2);
    endfunction

    // Reference model: decide the fate of one complete frame.
    task automatic model_commit(input int i, input int d, input bit par_ok, input bit stop_ok);
        if (!stop_ok)                 efe[i] = 1'b1;
        else if (!par_ok)             epe[i] = 1'b1;
        else if (qsize(i) == depth(i)) eov[i] = 1'b1;
        else case (i)
            0: q0.push_back(d);
            1: q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic bit_out(input int i, input logic v);
        ln[i] = v;
        repeat (BT) @(negedge clk);
    endtask

    // bad_stop: index of the stop bit to drive low, or -1 for a clean frame.
    task automatic send_frame(input int i, input int d, input bit flip_par, input int bad_stop);
        int nb, dm, p;
        nb = dbits(i);
        dm = d & ((1 << nb) - 1);
        p  = $countones(dm) % 2;             // even parity bit
        if (pmode(i) == 1) p = 1 - p;        // odd parity bit
        if (flip_par) p = 1 - p;
        bit_out(i, 1'b0);
        for (int b = 0; b < nb; b++) bit_out(i, logic'((dm >> b) & 1));
        if (pmode(i) != 0) bit_out(i, logic'(p));
        for (int s = 0; s < nstop(i); s++) bit_out(i, (s == bad_stop) ? 1'b0 : 1'b1);
        ln[i] = 1'b1;
        model_commit(i, dm, !(flip_par && pmode(i) != 0), bad_stop < 0);
    endtask

    task automatic settle();
        repeat (BT + 4) @(negedge clk);
    endtask

    task automatic check_state(input int i, input string tag);
        check({tag, "_count"}, get_cnt(i), qsize(i));
        check({tag, "_valid"}, int'(vld[i]), int'(qsize(i) != 0));
        check({tag, "_frame_err"}, int'(fe[i]), int'(efe[i]));
        check({tag, "_parity_err"}, int'(pe[i]), int'(epe[i]));
        check({tag, "_overrun"}, int'(ov[i]), int'(eov[i]));
    endtask

    task automatic pop_check(input int i, input string tag);
        int e;
        if (qsize(i) == 0) begin
            check({tag, "_valid"}, int'(vld[i]), 0);
            return;
        end
        case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        check({tag, "_valid"}, int'(vld[i]), 1);
        check({tag, "_data"}, get_data(i), e);
        rdy[i] = 1'b1;
        @(negedge clk);
        rdy[i] = 1'b0;
    endtask

    task automatic clear_err(input int i);
        clr[i] = 1'b1;
        @(negedge clk);
        clr[i] = 1'b0;
        efe[i] = 1'b0;
        epe[i] = 1'b0;
        eov[i] = 1'b0;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int i = 0; i < 3; i++) begin
            efe[i] = 1'b0;
            epe[i] = 1'b0;
            eov[i] = 1'b0;
        end
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        bit f;
        int bs;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_state(i, "reset");
            check("reset_data", get_data(i), 0);
        end
        repeat (4) @(negedge clk);

        // 8N1 back-to-back, held in the FIFO, then drained in order
        for (int k = 0; k < 4; k++) send_frame(0, 'h61 + k, 1'b0, -1);
        settle();
        check_state(0, "b2b");
        for (int k = 0; k < 4; k++) pop_check(0, "b2b_pop");
        check_state(0, "b2b_drained");

        // sustained traffic into a full FIFO
        for (int k = 0; k < 12; k++) send_frame(0, int'($urandom_range(0, 255)), 1'b0, -1);
        settle();
        check_state(0, "ovr");
        for (int k = 0; k < 8; k++) pop_check(0, "ovr_pop");
        clear_err(0);
        check_state(0, "ovr_clr");

        // framing error followed by a line break
        send_frame(0, 'h55, 1'b0, 0);
        ln[0] = 1'b0;
        repeat (20 * BT) @(negedge clk);
        ln[0] = 1'b1;
        settle();
        check_state(0, "brk");
        send_frame(0, 'h5A, 1'b0, -1);
        settle();
        check_state(0, "brk_next");
        pop_check(0, "brk_pop");
        clear_err(0);

        // short low glitch is rejected as a false start
        ln[0] = 1'b0;
        repeat (BT / 4) @(negedge clk);
        ln[0] = 1'b1;
        settle();
        check_state(0, "glitch");
        send_frame(0, int'($urandom_range(0, 255)), 1'b0, -1);
        settle();
        pop_check(0, "glitch_pop");

        // reset during data bit 3 with two entries held
        send_frame(0, 'h11, 1'b0, -1);
        send_frame(0, 'h22, 1'b0, -1);
        settle();
        check_state(0, "pre_rst");
        bit_out(0, 1'b0);
        for (int b = 0; b < 3; b++) bit_out(0, 1'b1);
        ln[0] = 1'b0;
        repeat (BT / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_state(0, "rst_mid");
        check("rst_mid_data", get_data(0), 0);
        repeat (BT / 2 - 2) @(negedge clk);
        for (int b = 4; b < 8; b++) bit_out(0, 1'b0);
        bit_out(0, 1'b1);
        settle();
        check_state(0, "rst_tail");
        send_frame(0, 'h3C, 1'b0, -1);
        settle();
        pop_check(0, "rst_next");

        // 7E1: good parity, then flipped parity
        send_frame(1, 'h41, 1'b0, -1);
        settle();
        check_state(1, "par_ok");
        pop_check(1, "par_ok_pop");
        send_frame(1, 'h41, 1'b1, -1);
        settle();
        check_state(1, "par_bad");
        clear_err(1);

        // 7E1 randomized frames with occasional parity or stop faults
        for (int k = 0; k < 12; k++) begin
            d  = int'($urandom_range(0, 127));
            f  = ($urandom_range(0, 2) == 0);
            bs = ($urandom_range(0, 4) == 0) ? 0 : -1;
            send_frame(1, d, f, bs);
            settle();
            check_state(1, "rnd");
            if (qsize(1) != 0) pop_check(1, "rnd_pop");
            clear_err(1);
        end

        // 9O2 corner format
        send_frame(2, 'h1A5, 1'b0, -1);
        settle();
        check_state(2, "c9");
        pop_check(2, "c9_pop");
        send_frame(2, 'h1A5, 1'b0, 1);
        settle();
        check_state(2, "c9_stop2");
        clear_err(2);
        for (int k = 0; k < 3; k++) send_frame(2, int'($urandom_range(0, 511)), 1'b0, -1);
        settle();
        check_state(2, "c9_ovr");
        pop_check(2, "c9_ovr_pop");
        pop_check(2, "c9_ovr_pop");
        clear_err(2);
        check_state(2, "c9_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
